// File: rtl/spare_chain_loader.sv
// Bit-serial loader for the spare-logic tile configuration chain.
// Shifts a captured image out MSB first, then strobes a chain-wide load; also runs a chain clear.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; clear (priority) or req accepted here only
// SHIFT | clocking image out, 2*CLK_DIV cycles per bit
// LOAD  | serial_load high for CLK_DIV cycles, serial_clock low
// CLEAR | serial_resetn low for CLK_DIV cycles
// DONE  | one-cycle done pulse, busy still high
module spare_chain_loader #(
  parameter int NUM_BLOCKS = 4,
  parameter int WORD_W     = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         req,
  input  logic                         clear,
  input  logic [NUM_BLOCKS*WORD_W-1:0] cfg_data,
  output logic                         busy,
  output logic                         done,
  output logic                         serial_clock,
  output logic                         serial_data,
  output logic                         serial_load,
  output logic                         serial_resetn
);

  localparam int TOTAL = NUM_BLOCKS * WORD_W;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [TOTAL-1:0]   sreg_q, sreg_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic sload_q, sload_d;
  logic srstn_q, srstn_d;

  logic div_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sreg_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sload_q <= 1'b0;
      srstn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sload_q <= sload_d;
      srstn_q <= srstn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    sreg_d   = sreg_q;
    div_last = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        if (clear) begin
          state_d = ST_CLEAR;
        end else if (req) begin
          state_d = ST_SHIFT;
          sreg_d  = cfg_data;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of the high phase: advance to the next bit.
            phase_d = 1'b0;
            sreg_d  = {sreg_q[TOTAL-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOAD, ST_CLEAR: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
        bit_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so the flops line up with state_q.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    sclk_d  = (state_d == ST_SHIFT) && phase_d;
    sdata_d = (state_d == ST_SHIFT) && sreg_d[TOTAL-1];
    sload_d = (state_d == ST_LOAD);
    srstn_d = (state_d != ST_CLEAR);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdata_q;
  assign serial_load   = sload_q;
  assign serial_resetn = srstn_q;

endmodule
